// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: same-cycle hits,
// one 128-bit line refill per miss from the slow memory port.
module icache_direct_mapped #(
  parameter int NUM_BLOCKS = 8,
  parameter int ADDR_W     = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [31:0]       proc_wdata,
  output logic [31:0]       proc_rdata,
  output logic              proc_stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic [127:0]      mem_rdata,
  input  logic              mem_ready
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  localparam int LA_W  = ADDR_W - 2;

  typedef enum logic {IDLE, ALLOC} state_t;

  state_t state;
  state_t state_nx;

  logic [NUM_BLOCKS-1:0] valid;
  logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
  logic [127:0]          data_mem [NUM_BLOCKS];
  logic [LA_W-1:0]       miss_addr;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       word;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [127:0]     line;
  logic             hit;
  logic             fill;
  logic             unused;

  assign idx      = proc_addr[IDX_W+1:2];
  assign tag      = proc_addr[ADDR_W-1:IDX_W+2];
  assign word     = proc_addr[1:0];
  assign fill_idx = miss_addr[IDX_W-1:0];
  assign fill_tag = miss_addr[LA_W-1:IDX_W];
  assign line     = data_mem[idx];
  assign hit      = valid[idx] && (tag_mem[idx] == tag);
  assign fill     = (state == ALLOC) && mem_ready;

  assign mem_write = 1'b0;
  assign mem_wdata = '0;
  assign mem_addr  = miss_addr;
  assign unused    = ^{proc_write, proc_wdata};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid     <= '0;
      miss_addr <= '0;
    end else begin
      if (state == IDLE && proc_read && !hit)
        miss_addr <= proc_addr[ADDR_W-1:2];
      if (fill)
        valid[fill_idx] <= 1'b1;
    end
  end

  // Arrays need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (rst_n && fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_rdata;
    end
  end

  always_comb begin
    state_nx   = state;
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    proc_rdata = '0;
    if (rst_n) begin
      proc_rdata = line[{word, 5'd0} +: 32];
      unique case (state)
        IDLE: begin
          proc_stall = proc_read && !hit;
          if (proc_stall) state_nx = ALLOC;
        end
        ALLOC: begin
          proc_stall = 1'b1;
          mem_read   = 1'b1;
          if (mem_ready) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench for icache_direct_mapped: per-cycle vector
// table plus a random-latency refill sequence, via a scoreboard.
module tb_icache_direct_mapped;

  logic         clk;
  logic         rst_n;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  icache_direct_mapped dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic         rd;
    logic         wr;
    logic [29:0]  addr;
    logic         rdy;
    logic [127:0] line;
    logic         stall;
    logic         mread;
    bit           chk_ma;
    logic [27:0]  ma;
    bit           chk_rd;
    logic [31:0]  rdata;
  } vec_t;

  typedef struct {
    logic        stall;
    logic        mread;
    bit          chk_ma;
    logic [27:0] ma;
    bit          chk_rd;
    logic [31:0] rdata;
    int          row;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests;
  int   fails;

  function automatic logic [127:0] mk_line(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  function automatic vec_t v(
    input logic rn, input logic rd, input logic wr,
    input logic [29:0] a, input logic rdy,
    input logic [127:0] ln, input logic st,
    input logic mr, input bit cm, input logic [27:0] ma,
    input bit cr, input logic [31:0] rdat);
    vec_t t;
    t.rst_n = rn; t.rd = rd; t.wr = wr; t.addr = a;
    t.rdy = rdy; t.line = ln; t.stall = st;
    t.mread = mr; t.chk_ma = cm; t.ma = ma;
    t.chk_rd = cr; t.rdata = rdat;
    return t;
  endfunction

  task automatic chk(input string nm, input int row,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %0h want %0h",
               nm, row, act, exp);
    end
  endtask

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard empty");
      return;
    end
    e = sb.pop_front();
    chk("stall", e.row, 128'(proc_stall), 128'(e.stall));
    chk("mem_read", e.row, 128'(mem_read), 128'(e.mread));
    if (e.chk_ma)
      chk("mem_addr", e.row, 128'(mem_addr), 128'(e.ma));
    if (e.chk_rd)
      chk("rdata", e.row, 128'(proc_rdata), 128'(e.rdata));
  endtask

  logic [127:0] l0, l1, l2, l3, l4, junk;
  localparam logic [27:0] X = 28'h0;

  initial begin
    tests = 0; fails = 0;
    l0 = mk_line(32'hA000_0000);
    l1 = mk_line(32'hB000_0000);
    l2 = mk_line(32'hC000_0000);
    l3 = mk_line(32'hD000_0000);
    l4 = mk_line(32'hE000_0000);
    junk = {4{32'hDEAD_BEEF}};
    rst_n = 0; proc_read = 0; proc_write = 0;
    proc_addr = '0; proc_wdata = 32'h1234_5678;
    mem_rdata = '0; mem_ready = 0;

    // reset forces outputs low
    vecs.push_back(v(0,1,0,30'h0,0,'0,0,0,0,X,1,0));
    vecs.push_back(v(0,0,0,30'h0,0,'0,0,0,0,X,1,0));
    // 1: cold miss, 5-cycle memory latency
    vecs.push_back(v(1,1,0,30'h0,0,'0,1,0,1,0,0,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(1,1,0,30'h0,0,'0,1,1,1,0,0,0));
    vecs.push_back(v(1,1,0,30'h0,1,l0,1,1,1,0,0,0));
    vecs.push_back(v(1,1,0,30'h0,0,'0,0,0,0,X,1,l0[31:0]));
    // 2: rest of line hits
    vecs.push_back(v(1,1,0,30'h1,0,'0,0,0,0,X,1,l0[63:32]));
    vecs.push_back(v(1,1,0,30'h2,0,'0,0,0,0,X,1,l0[95:64]));
    vecs.push_back(v(1,1,0,30'h3,0,'0,0,0,0,X,1,l0[127:96]));
    // 3: conflict on index 0
    vecs.push_back(v(1,1,0,30'h20,0,'0,1,0,0,X,0,0));
    vecs.push_back(v(1,1,0,30'h20,0,'0,1,1,1,28'h8,0,0));
    vecs.push_back(v(1,1,0,30'h20,1,l1,1,1,1,28'h8,0,0));
    vecs.push_back(v(1,1,0,30'h20,0,'0,0,0,0,X,1,l1[31:0]));
    vecs.push_back(v(1,1,0,30'h0,0,'0,1,0,1,28'h8,0,0));
    vecs.push_back(v(1,1,0,30'h0,1,l0,1,1,1,28'h0,0,0));
    vecs.push_back(v(1,1,0,30'h0,0,'0,0,0,0,X,1,l0[31:0]));
    // 4: proc_read dropped during refill
    vecs.push_back(v(1,1,0,30'h4,0,'0,1,0,0,X,0,0));
    vecs.push_back(v(1,0,0,30'h4,0,'0,1,1,1,28'h1,0,0));
    vecs.push_back(v(1,0,0,30'h4,0,'0,1,1,1,28'h1,0,0));
    vecs.push_back(v(1,0,0,30'h4,1,l2,1,1,1,28'h1,0,0));
    vecs.push_back(v(1,0,0,30'h4,0,'0,0,0,0,X,0,0));
    vecs.push_back(v(1,1,0,30'h4,0,'0,0,0,0,X,1,l2[31:0]));
    vecs.push_back(v(1,1,0,30'h7,0,'0,0,0,0,X,1,l2[127:96]));
    // stray mem_ready in IDLE must not touch the array
    vecs.push_back(v(1,0,0,30'h24,1,junk,0,0,0,X,0,0));
    vecs.push_back(v(1,1,0,30'h4,0,'0,0,0,0,X,1,l2[31:0]));
    // 5: reset during ALLOC
    vecs.push_back(v(1,1,0,30'h8,0,'0,1,0,0,X,0,0));
    vecs.push_back(v(1,1,0,30'h8,0,'0,1,1,1,28'h2,0,0));
    vecs.push_back(v(0,1,0,30'h8,0,'0,0,0,0,X,1,0));
    vecs.push_back(v(1,0,0,30'h8,1,junk,0,0,1,28'h0,0,0));
    vecs.push_back(v(1,1,0,30'h8,0,'0,1,0,1,28'h0,0,0));
    vecs.push_back(v(1,1,0,30'h8,1,l3,1,1,1,28'h2,0,0));
    vecs.push_back(v(1,1,0,30'h8,0,'0,0,0,0,X,1,l3[31:0]));
    vecs.push_back(v(1,1,0,30'h4,0,'0,1,0,0,X,0,0));
    vecs.push_back(v(0,0,0,30'h0,0,'0,0,0,0,X,1,0));
    // 6: writes are ignored
    vecs.push_back(v(1,0,1,30'h10,0,'0,0,0,0,X,0,0));
    vecs.push_back(v(1,0,1,30'h30,0,'0,0,0,0,X,0,0));
    vecs.push_back(v(1,1,0,30'h10,0,'0,1,0,0,X,0,0));
    vecs.push_back(v(0,0,0,30'h0,0,'0,0,0,0,X,1,0));

    foreach (vecs[i]) begin
      exp_t e;
      @(negedge clk);
      rst_n      = vecs[i].rst_n;
      proc_read  = vecs[i].rd;
      proc_write = vecs[i].wr;
      proc_addr  = vecs[i].addr;
      mem_ready  = vecs[i].rdy;
      mem_rdata  = vecs[i].line;
      e.stall = vecs[i].stall; e.mread = vecs[i].mread;
      e.chk_ma = vecs[i].chk_ma; e.ma = vecs[i].ma;
      e.chk_rd = vecs[i].chk_rd; e.rdata = vecs[i].rdata;
      e.row = i;
      sb.push_back(e);
      #1;
      check_front();
    end

    // random-latency refill of index 3, bounded wait
    begin
      int lat, n, st_cyc;
      bit done;
      lat = $urandom_range(1, 6);
      n = 0; st_cyc = 0; done = 0;
      for (int c = 0; c < 30 && !done; c++) begin
        @(negedge clk);
        rst_n = 1; proc_write = 0;
        proc_read = 1; proc_addr = 30'hE;
        if (mem_read) n++;
        mem_ready = (n == lat);
        mem_rdata = mem_ready ? l4 : '0;
        if (mem_read)
          chk("lat_mem_addr", c, 128'(mem_addr), 128'h3);
        #1;
        if (proc_stall) st_cyc++;
        else done = 1;
      end
      mem_ready = 0;
      if (!done) begin
        tests++; fails++;
        $display("FAIL lat_timeout: stall never fell");
      end else begin
        chk("lat_stall_cycles", lat, 128'(st_cyc),
            128'(lat + 1));
        chk("lat_rdata", lat, 128'(proc_rdata),
            128'(l4[95:64]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
